// File: rtl/stream_demux_1x2_pkg.sv
// Shared widths, select encodings and output-stage state type for the 1x2 demux.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package stream_demux_1x2_pkg;

    localparam int DEF_W     = 3;
    localparam int DEF_CNT_W = 8;

    localparam logic SEL_F0 = 1'b0;
    localparam logic SEL_F1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/stream_demux_1x2_out_stage.sv
// One-entry registered output stage: holds a single word until the consumer takes it.
// Latency: 1 cycle from load to q_valid.
// Backpressure: room drops while full and out_ready is low; drain and refill in one cycle.
module demux_out_stage
    import stream_demux_1x2_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic         q_valid,
    output logic         room
);

    stage_state_t state_q;
    stage_state_t state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // load is only ever asserted when room is high, so FULL+load implies a drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !load) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Data is not cleared on drain; it keeps the last loaded word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

    assign q_valid = (state_q == ST_FULL);
    assign room    = !q_valid || out_ready;

endmodule

// File: rtl/stream_demux_1x2.sv
// Registered 1-to-2 stream demux with per-output accept counters.
// Latency: 1 cycle from accept to fN_valid.
// Backpressure: in_ready follows only the stage selected by s; the other stage never blocks.
module stream_demux_1x2
    import stream_demux_1x2_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     x,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     f0,
    output logic             f0_valid,
    input  logic             f0_ready,
    output logic [W-1:0]     f1,
    output logic             f1_valid,
    input  logic             f1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic room0;
    logic room1;
    logic accept;
    logic load0;
    logic load1;

    assign in_ready = (s == SEL_F1) ? room1 : room0;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && (s == SEL_F0);
    assign load1    = accept && (s == SEL_F1);

    demux_out_stage #(.W(W)) u_stage0 (
        .clk       (clk),
        .reset     (reset),
        .load      (load0),
        .d         (x),
        .out_ready (f0_ready),
        .q         (f0),
        .q_valid   (f0_valid),
        .room      (room0)
    );

    demux_out_stage #(.W(W)) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .load      (load1),
        .d         (x),
        .out_ready (f1_ready),
        .q         (f1),
        .q_valid   (f1_valid),
        .room      (room1)
    );

    // Counters track accepts only; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (load0) cnt0 <= cnt0 + CNT_W'(1);
            if (load1) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Bench for stream_demux_1x2: vector table, directed corner sequences, random vs queue model.
module tb_stream_demux_1x2;

    logic       clk;
    logic       reset;
    logic [2:0] x;
    logic       s;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] f0;
    logic       f0_valid;
    logic       f0_ready;
    logic [2:0] f1;
    logic       f1_valid;
    logic       f1_ready;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    logic       d2_in_ready;
    logic [2:0] d2_f0;
    logic       d2_f0_valid;
    logic [2:0] d2_f1;
    logic       d2_f1_valid;
    logic [1:0] d2_cnt0;
    logic [1:0] d2_cnt1;

    int total;
    int passed;

    stream_demux_1x2 #(.W(3), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .x(x), .s(s), .in_valid(in_valid), .in_ready(in_ready),
        .f0(f0), .f0_valid(f0_valid), .f0_ready(f0_ready),
        .f1(f1), .f1_valid(f1_valid), .f1_ready(f1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    stream_demux_1x2 #(.W(3), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .x(x), .s(s), .in_valid(in_valid), .in_ready(d2_in_ready),
        .f0(d2_f0), .f0_valid(d2_f0_valid), .f0_ready(f0_ready),
        .f1(d2_f1), .f1_valid(d2_f1_valid), .f1_ready(f1_ready),
        .cnt0(d2_cnt0), .cnt1(d2_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else passed++;
    endtask

    typedef struct {
        logic       iv;
        logic       sel;
        logic [2:0] xd;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_f0v;
        logic [2:0] e_f0;
        logic       e_f1v;
        logic [2:0] e_f1;
        logic [7:0] e_c0;
        logic [7:0] e_c1;
    } vec_t;

    vec_t tbl[7];

    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] last0, last1;
    int         m0, m1;
    logic       hold, rm0, rm1, er, acc;
    logic [2:0] exp_f;

    initial begin
        total = 0; passed = 0;
        reset = 1'b1; x = '0; s = 1'b0; in_valid = 1'b0; f0_ready = 1'b0; f1_ready = 1'b0;

        // route, idle drain, stall on f1, bypass via f0, release f1, dual drain
        tbl[0] = '{1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 8'd1, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 3'd0, 8'd1, 8'd0};
        tbl[2] = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 3'd3, 8'd1, 8'd1};
        tbl[3] = '{1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd3, 8'd1, 8'd1};
        tbl[4] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 3'd3, 8'd2, 8'd1};
        tbl[5] = '{1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 3'd6, 8'd2, 8'd2};
        tbl[6] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 3'd6, 8'd2, 8'd2};

        #3;
        chk("rst_f0_valid", f0_valid, 0);
        chk("rst_f1_valid", f1_valid, 0);
        chk("rst_f0", f0, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        s = 1'b0; #1 chk("rst_in_ready_s0", in_ready, 1);
        s = 1'b1; #1 chk("rst_in_ready_s1", in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            in_valid = tbl[i].iv; s = tbl[i].sel; x = tbl[i].xd;
            f0_ready = tbl[i].r0; f1_ready = tbl[i].r1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_f0_valid", i), f0_valid, tbl[i].e_f0v);
            chk($sformatf("vec%0d_f0", i), f0, tbl[i].e_f0);
            chk($sformatf("vec%0d_f1_valid", i), f1_valid, tbl[i].e_f1v);
            chk($sformatf("vec%0d_f1", i), f1, tbl[i].e_f1);
            chk($sformatf("vec%0d_cnt0", i), cnt0, tbl[i].e_c0);
            chk($sformatf("vec%0d_cnt1", i), cnt1, tbl[i].e_c1);
        end

        // async reset mid-cycle with f0 full
        in_valid = 1'b1; s = 1'b0; x = 3'd2; f0_ready = 1'b0; f1_ready = 1'b0;
        @(posedge clk); #1;
        chk("arst_pre_f0_valid", f0_valid, 1);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("arst_f0_valid", f0_valid, 0);
        chk("arst_f1_valid", f1_valid, 0);
        chk("arst_f0", f0, 0);
        chk("arst_f1", f1, 0);
        chk("arst_cnt0", cnt0, 0);
        chk("arst_cnt1", cnt1, 0);
        #1 reset = 1'b0;
        s = 1'b0; #1 chk("arst_in_ready_s0", in_ready, 1);
        s = 1'b1; #1 chk("arst_in_ready_s1", in_ready, 1);

        // full throughput 0..7 on f0
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; s = 1'b0; x = 3'(i); f0_ready = 1'b1;
            #1 chk($sformatf("thr%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("thr%0d_f0", i), f0, i);
            chk($sformatf("thr%0d_f0_valid", i), f0_valid, 1);
        end
        chk("thr_cnt0", cnt0, 8);

        // select change while f0 stalled
        f0_ready = 1'b0; f1_ready = 1'b0; in_valid = 1'b1; s = 1'b0; x = 3'd4;
        #1 chk("sel_stall_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("sel_stall_f0", f0, 7);
        chk("sel_stall_f0_valid", f0_valid, 1);
        chk("sel_stall_cnt0", cnt0, 8);
        s = 1'b1;
        #1 chk("sel_switch_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("sel_switch_f1", f1, 4);
        chk("sel_switch_f1_valid", f1_valid, 1);
        chk("sel_switch_f0", f0, 7);
        chk("sel_switch_cnt0", cnt0, 8);
        chk("sel_switch_cnt1", cnt1, 1);

        // counter wrap on the 2-bit instance
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; s = 1'b1; x = 3'(i); f1_ready = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("wrap%0d_cnt1", i), d2_cnt1, (i + 1) % 4);
        end
        in_valid = 1'b0;

        // random traffic against a queue model
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        q0.delete(); q1.delete();
        last0 = '0; last1 = '0; m0 = 0; m1 = 0; hold = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                s = 1'($urandom_range(0, 1));
                x = 3'($urandom_range(0, 7));
            end
            f0_ready = ($urandom_range(0, 3) != 0);
            f1_ready = 1'($urandom_range(0, 1));
            #1;
            rm0 = (q0.size() == 0) || f0_ready;
            rm1 = (q1.size() == 0) || f1_ready;
            er  = s ? rm1 : rm0;
            chk("rnd_in_ready", in_ready, er);
            acc = in_valid && er;
            @(posedge clk); #1;
            if (f0_ready && q0.size() > 0) void'(q0.pop_front());
            if (f1_ready && q1.size() > 0) void'(q1.pop_front());
            if (acc) begin
                if (s) begin q1.push_back(x); last1 = x; m1++; end
                else   begin q0.push_back(x); last0 = x; m0++; end
            end
            chk("rnd_f0_valid", f0_valid, q0.size() > 0);
            exp_f = (q0.size() > 0) ? q0[0] : last0;
            chk("rnd_f0", f0, exp_f);
            chk("rnd_f1_valid", f1_valid, q1.size() > 0);
            exp_f = (q1.size() > 0) ? q1[0] : last1;
            chk("rnd_f1", f1, exp_f);
            chk("rnd_cnt0", cnt0, m0 % 256);
            chk("rnd_cnt1", cnt1, m1 % 256);
            chk("rnd_w2_cnt0", d2_cnt0, m0 % 4);
            chk("rnd_w2_cnt1", d2_cnt1, m1 % 4);
            hold = in_valid && !er;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
